// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-serial RAM/IO port arbiter between instruction fetch and load/store buffer
// Optional macro MC_ROUND_ROBIN_EN: alternate on simultaneous requests (default: LSB always wins).
module mem_arbiter (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        if_to_mc_ready,
  input  logic [31:0] if_to_mc_PC,
  output logic        mc_to_if_ready,
  output logic [31:0] mc_to_if_inst,
  output logic [31:0] mc_to_if_addr,
  input  logic        lsb_to_mc_ready,
  input  logic        lsb_to_mc_wr,
  input  logic [31:0] lsb_to_mc_addr,
  input  logic [1:0]  lsb_to_mc_len,
  input  logic [31:0] lsb_to_mc_data,
  output logic        mc_to_lsb_ready,
  output logic [31:0] mc_to_lsb_data
);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_DONE} state_t;

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  n_q;
  logic [31:0] base_q;
  logic [31:0] wdata_q;
  logic [31:0] buf_q;
  logic        sel_lsb_q;
  logic        if_ready_q;
  logic        lsb_ready_q;
  logic [31:0] if_inst_q;
  logic [31:0] if_addr_q;
  logic [31:0] lsb_data_q;
`ifdef MC_ROUND_ROBIN_EN
  logic        last_lsb_q;
`endif

  logic        if_req_d;
  logic        lsb_req_d;
  logic        pick_lsb_d;
  logic        io_stall_d;
  logic [2:0]  lsb_n_d;
  logic [31:0] rd_word_d;

  // A flush kills pending fetches and loads, but a store is already committed.
  always_comb begin
    if_req_d   = if_to_mc_ready && !clr_in;
    lsb_req_d  = lsb_to_mc_ready && (lsb_to_mc_wr || !clr_in);
    pick_lsb_d = lsb_req_d;
`ifdef MC_ROUND_ROBIN_EN
    if (if_req_d && lsb_req_d) begin
      pick_lsb_d = !last_lsb_q;
    end
`endif
    case (lsb_to_mc_len)
      2'b00:   lsb_n_d = 3'd1;
      2'b01:   lsb_n_d = 3'd2;
      default: lsb_n_d = 3'd4;
    endcase
  end

  // mem_din lags the address by one cycle, so index cnt captures lane cnt-1.
  always_comb begin
    rd_word_d = buf_q;
    case (cnt_q)
      3'd1:    rd_word_d[7:0]   = mem_din;
      3'd2:    rd_word_d[15:8]  = mem_din;
      3'd3:    rd_word_d[23:16] = mem_din;
      3'd4:    rd_word_d[31:24] = mem_din;
      default: rd_word_d        = buf_q;
    endcase
  end

  assign io_stall_d = (base_q[17:16] == 2'b11) && io_buffer_full;
  assign mem_wr     = rdy_in && (state_q == S_WRITE) && !io_stall_d;

  always_comb begin
    mem_a    = 32'd0;
    mem_dout = 8'd0;
    if (state_q == S_WRITE || (state_q == S_READ && cnt_q < n_q)) begin
      mem_a = base_q + {29'd0, cnt_q};
    end
    if (state_q == S_WRITE) begin
      case (cnt_q[1:0])
        2'd0:    mem_dout = wdata_q[7:0];
        2'd1:    mem_dout = wdata_q[15:8];
        2'd2:    mem_dout = wdata_q[23:16];
        default: mem_dout = wdata_q[31:24];
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= 32'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      sel_lsb_q   <= 1'b0;
      if_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      if_inst_q   <= 32'd0;
      if_addr_q   <= 32'd0;
      lsb_data_q  <= 32'd0;
`ifdef MC_ROUND_ROBIN_EN
      last_lsb_q  <= 1'b0;
`endif
    end else if (rdy_in) begin
      if_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (if_req_d || lsb_req_d) begin
            base_q    <= pick_lsb_d ? lsb_to_mc_addr : if_to_mc_PC;
            n_q       <= pick_lsb_d ? lsb_n_d : 3'd4;
            wdata_q   <= lsb_to_mc_data;
            sel_lsb_q <= pick_lsb_d;
            buf_q     <= 32'd0;
            cnt_q     <= 3'd0;
            state_q   <= (pick_lsb_d && lsb_to_mc_wr) ? S_WRITE : S_READ;
`ifdef MC_ROUND_ROBIN_EN
            last_lsb_q <= pick_lsb_d;
`endif
          end
        end
        S_READ: begin
          if (clr_in) begin
            state_q <= S_IDLE;
          end else begin
            buf_q <= rd_word_d;
            if (cnt_q == n_q) begin
              state_q <= S_DONE;
              if (sel_lsb_q) begin
                lsb_ready_q <= 1'b1;
                lsb_data_q  <= rd_word_d;
              end else begin
                if_ready_q <= 1'b1;
                if_inst_q  <= rd_word_d;
                if_addr_q  <= base_q;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        S_WRITE: begin
          if (!io_stall_d) begin
            if (cnt_q == n_q - 3'd1) begin
              state_q     <= S_DONE;
              lsb_ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mc_to_if_ready  = if_ready_q;
  assign mc_to_if_inst   = if_inst_q;
  assign mc_to_if_addr   = if_addr_q;
  assign mc_to_lsb_ready = lsb_ready_q;
  assign mc_to_lsb_data  = lsb_data_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - table-driven and directed checks for mem_arbiter
module tb_mem_arbiter;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        if_to_mc_ready;
  logic [31:0] if_to_mc_PC;
  logic        mc_to_if_ready;
  logic [31:0] mc_to_if_inst, mc_to_if_addr;
  logic        lsb_to_mc_ready, lsb_to_mc_wr;
  logic [31:0] lsb_to_mc_addr;
  logic [1:0]  lsb_to_mc_len;
  logic [31:0] lsb_to_mc_data;
  logic        mc_to_lsb_ready;
  logic [31:0] mc_to_lsb_data;

  mem_arbiter dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full),
    .if_to_mc_ready(if_to_mc_ready), .if_to_mc_PC(if_to_mc_PC),
    .mc_to_if_ready(mc_to_if_ready), .mc_to_if_inst(mc_to_if_inst), .mc_to_if_addr(mc_to_if_addr),
    .lsb_to_mc_ready(lsb_to_mc_ready), .lsb_to_mc_wr(lsb_to_mc_wr), .lsb_to_mc_addr(lsb_to_mc_addr),
    .lsb_to_mc_len(lsb_to_mc_len), .lsb_to_mc_data(lsb_to_mc_data),
    .mc_to_lsb_ready(mc_to_lsb_ready), .mc_to_lsb_data(mc_to_lsb_data)
  );

  always #5 clk_in = ~clk_in;

  // RAM folded onto {addr[17:16], addr[7:0]}; read data appears one cycle after the address.
  logic [7:0] ram [1024];
  int wr_count = 0;
  always @(posedge clk_in) begin
    mem_din <= ram[{mem_a[17:16], mem_a[7:0]}];
    if (mem_wr) begin
      ram[{mem_a[17:16], mem_a[7:0]}] = mem_dout;
      wr_count = wr_count + 1;
    end
  end

  typedef struct {
    bit          is_if;
    bit          wr;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          stall;
    int          clr_at;
    int          rdy_off;
    int          exp_lat;
    logic [31:0] exp_data;
    bit          chk;
  } txn_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] tr_a [32];
  logic        tr_wr [32];
  logic [7:0]  tr_dout [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    if_to_mc_ready  = 1'b0;
    lsb_to_mc_ready = 1'b0;
    clr_in          = 1'b0;
    io_buffer_full  = 1'b0;
    rdy_in          = 1'b1;
  endtask

  // k counts negedges from the request cycle R (k = 0); lat = -1 if no done pulse.
  task automatic run_txn(input txn_t t, output int lat, output logic [31:0] data,
                         output logic [31:0] addr_o, output int wrong, output logic stuck);
    lat = -1; wrong = 0; data = '0; addr_o = '0; stuck = 1'b0;
    for (int k = 0; k <= 30 && lat < 0; k++) begin
      @(negedge clk_in);
      if (k == 0) begin
        if (t.is_if) begin
          if_to_mc_ready = 1'b1;
          if_to_mc_PC    = t.addr;
        end else begin
          lsb_to_mc_ready = 1'b1;
          lsb_to_mc_wr    = t.wr;
          lsb_to_mc_addr  = t.addr;
          lsb_to_mc_len   = t.len;
          lsb_to_mc_data  = t.wdata;
        end
      end
      clr_in = (k == t.clr_at);
      if (k == t.clr_at && k > 0 && !t.wr) begin
        if_to_mc_ready  = 1'b0;
        lsb_to_mc_ready = 1'b0;
      end
      io_buffer_full = (t.stall > 0) && (k <= t.stall);
      rdy_in = !(t.rdy_off > 0 && (k == t.rdy_off || k == t.rdy_off + 1));
      #1;
      if (k >= 1) begin
        tr_a[k] = mem_a; tr_wr[k] = mem_wr; tr_dout[k] = mem_dout;
        if (t.is_if ? mc_to_if_ready : mc_to_lsb_ready) begin
          lat    = k;
          data   = t.is_if ? mc_to_if_inst : mc_to_lsb_data;
          addr_o = mc_to_if_addr;
        end
        if (t.is_if ? mc_to_lsb_ready : mc_to_if_ready) wrong++;
      end
    end
    idle_inputs();
    @(negedge clk_in);
    #1;
    stuck = mc_to_if_ready | mc_to_lsb_ready;
  endtask

  txn_t tv [19];
  int lat, wrong, wc0;
  logic [31:0] data, addr_o;
  logic stuck;
  logic [31:0] wv;
  txn_t t;

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    //      if wr len    addr           wdata        st clr rdy lat data           chk
    tv[0]  = '{1, 0, 2'd2, 32'h0000_0010, 32'h0,       0, -1, 0, 6, 32'h0000_0513, 1};
    tv[1]  = '{0, 0, 2'd1, 32'h0001_FFFE, 32'h0,       0, -1, 0, 4, 32'h0000_8234, 1};
    tv[2]  = '{0, 0, 2'd0, 32'h0001_FFFF, 32'h0,       0, -1, 0, 3, 32'h0000_0082, 1};
    tv[3]  = '{0, 0, 2'd2, 32'h0000_0010, 32'h0,       0, -1, 0, 6, 32'h0000_0513, 1};
    tv[4]  = '{0, 1, 2'd2, 32'h0000_0100, 32'hDEADBEEF, 0, -1, 0, 5, 32'h0,        0};
    tv[5]  = '{0, 1, 2'd1, 32'h0000_0020, 32'h12345678, 0, -1, 0, 3, 32'h0,        0};
    tv[6]  = '{0, 0, 2'd3, 32'h0000_0020, 32'h0,       0, -1, 0, 6, 32'h0000_5678, 1};
    tv[7]  = '{0, 0, 2'd3, 32'h0000_0100, 32'h0,       0, -1, 0, 6, 32'hDEADBEEF, 1};
    tv[8]  = '{1, 0, 2'd2, 32'hFFFF_FFFE, 32'h0,       0, -1, 0, 6, 32'hBEEF2211, 1};
    tv[9]  = '{1, 0, 2'd2, 32'h0000_0010, 32'h0,       0,  0, 0, 7, 32'h0000_0513, 1};
    tv[10] = '{0, 1, 2'd0, 32'h0000_0040, 32'h00000077, 0,  0, 0, 2, 32'h0,        0};
    tv[11] = '{0, 0, 2'd0, 32'h0000_0040, 32'h0,       0, -1, 0, 3, 32'h0000_0077, 1};
    tv[12] = '{1, 0, 2'd2, 32'h0000_0010, 32'h0,       0, -1, 2, 8, 32'h0,        0};
    tv[13] = '{0, 1, 2'd2, 32'h0000_0100, 32'hCAFEF00D, 0,  2, 0, 5, 32'h0,        0};
    tv[14] = '{0, 0, 2'd2, 32'h0000_0100, 32'h0,       0, -1, 0, 6, 32'hCAFEF00D, 1};
    tv[15] = '{1, 0, 2'd2, 32'h0000_0010, 32'h0,       0,  2, 0, -1, 32'h0,       0};
    tv[16] = '{0, 1, 2'd0, 32'h0003_0000, 32'h000000A5, 3, -1, 0, 5, 32'h0,        0};
    tv[17] = '{0, 1, 2'd0, 32'h0000_0040, 32'h00000099, 3, -1, 0, 2, 32'h0,        0};
    tv[18] = '{0, 0, 2'd0, 32'h0000_0040, 32'h0,       0, -1, 0, 3, 32'h0000_0099, 1};

    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h010] = 8'h13; ram[10'h011] = 8'h05;
    ram[10'h1FE] = 8'h34; ram[10'h1FF] = 8'h82;
    ram[10'h3FE] = 8'h11; ram[10'h3FF] = 8'h22;

    idle_inputs();
    rst_in = 1'b1;
    if_to_mc_PC = '0; lsb_to_mc_wr = 1'b0; lsb_to_mc_addr = '0;
    lsb_to_mc_len = '0; lsb_to_mc_data = '0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", {31'd0, mem_wr}, 32'h0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'h0);
    check("rst_if_ready", {31'd0, mc_to_if_ready}, 32'h0);
    check("rst_lsb_ready", {31'd0, mc_to_lsb_ready}, 32'h0);
    check("rst_if_inst", mc_to_if_inst, 32'h0);
    check("rst_if_addr", mc_to_if_addr, 32'h0);
    check("rst_lsb_data", mc_to_lsb_data, 32'h0);

    for (int i = 0; i < 19; i++) begin
      run_txn(tv[i], lat, data, addr_o, wrong, stuck);
      check($sformatf("v%0d_latency", i), lat, tv[i].exp_lat);
      if (tv[i].chk) check($sformatf("v%0d_data", i), data, tv[i].exp_data);
      if (tv[i].is_if && tv[i].exp_lat > 0) check($sformatf("v%0d_if_addr", i), addr_o, tv[i].addr);
      check($sformatf("v%0d_other_pulse", i), wrong, 0);
      check($sformatf("v%0d_pulse_width", i), {31'd0, stuck}, 32'h0);
    end

    // fetch address sequence
    t = tv[0];
    run_txn(t, lat, data, addr_o, wrong, stuck);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("fetch_mem_a_%0d", i), tr_a[i+1], 32'h10 + i);
      check($sformatf("fetch_mem_wr_%0d", i), {31'd0, tr_wr[i+1]}, 32'h0);
    end

    // word store byte stream
    t = tv[4];
    wv = 32'hDEADBEEF;
    t.wdata = wv;
    run_txn(t, lat, data, addr_o, wrong, stuck);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("store_wr_%0d", i), {31'd0, tr_wr[i+1]}, 32'h1);
      check($sformatf("store_dout_%0d", i), {24'd0, tr_dout[i+1]}, {24'd0, wv[8*i +: 8]});
      check($sformatf("store_a_%0d", i), tr_a[i+1], 32'h100 + i);
    end
    check("store_wr_done", {31'd0, tr_wr[5]}, 32'h0);

    // IO-stalled byte store
    t = tv[16];
    t.wdata = 32'h0000005A;
    wc0 = wr_count;
    run_txn(t, lat, data, addr_o, wrong, stuck);
    check("io_latency", lat, 5);
    check("io_write_count", wr_count - wc0, 1);
    check("io_ram_byte", {24'd0, ram[10'h300]}, 32'h5A);
    for (int i = 1; i <= 3; i++) check($sformatf("io_stall_wr_%0d", i), {31'd0, tr_wr[i]}, 32'h0);
    check("io_write_cycle", {31'd0, tr_wr[4]}, 32'h1);

    // simultaneous requesters, each with two loads queued
    begin
      logic [31:0] la [2];
      logic [1:0]  ll [2];
      logic [31:0] le [2];
      logic [31:0] ia [2];
      logic [31:0] ie [2];
      logic [7:0]  ord [4];
      logic [7:0]  exp_ord [4];
      int tim [4];
      int li, ii, nd;
      la = '{32'h0001_FFFE, 32'h0000_0100};
      ll = '{2'd1, 2'd2};
      le = '{32'h0000_8234, 32'hDEADBEEF};
      ia = '{32'h0000_0010, 32'h0000_0020};
      ie = '{32'h0000_0513, 32'h0000_5678};
`ifdef MC_ROUND_ROBIN_EN
      exp_ord = '{8'h4C, 8'h49, 8'h4C, 8'h49};
`else
      exp_ord = '{8'h4C, 8'h4C, 8'h49, 8'h49};
`endif
      li = 0; ii = 0; nd = 0;
      tim = '{0, 0, 0, 0};
      ord = '{8'h3F, 8'h3F, 8'h3F, 8'h3F};
      @(negedge clk_in);
      for (int c = 0; c <= 60 && nd < 4; c++) begin
        if (c > 0) begin
          @(negedge clk_in);
          #1;
          if (mc_to_lsb_ready && mc_to_if_ready) begin
            check("arb_single_pulse", 32'h1, 32'h0);
          end else if (mc_to_lsb_ready) begin
            check($sformatf("arb_lsb_data_%0d", li), mc_to_lsb_data, le[li % 2]);
            ord[nd] = 8'h4C; tim[nd] = c; nd++; li++;
          end else if (mc_to_if_ready) begin
            check($sformatf("arb_if_data_%0d", ii), mc_to_if_inst, ie[ii % 2]);
            ord[nd] = 8'h49; tim[nd] = c; nd++; ii++;
          end
        end
        lsb_to_mc_ready = (li < 2);
        lsb_to_mc_wr    = 1'b0;
        lsb_to_mc_addr  = la[li % 2];
        lsb_to_mc_len   = ll[li % 2];
        if_to_mc_ready  = (ii < 2);
        if_to_mc_PC     = ia[ii % 2];
      end
      idle_inputs();
      check("arb_count", nd, 4);
      for (int i = 0; i < 4; i++) check($sformatf("arb_order_%0d", i), {24'd0, ord[i]}, {24'd0, exp_ord[i]});
      check("arb_back_to_back_gap", tim[3] - tim[2], 7);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Memory arbiter for the RISC-V core's single byte-wide RAM/IO port. It shares the port between two requesters: the instruction fetcher (word reads) and the load/store buffer (byte/half/word loads and stores). It serialises each access into per-byte bus cycles, assembles or splits the data, and returns one-cycle completion pulses. It sits between the fetch/LSB units and the top-level `mem_din`/`mem_dout`/`mem_a`/`mem_wr` pins.

## Interface
- No parameters.
- `clk_in` input 1: clock.
- `rst_in` input 1: reset; one clock, synchronous, active-high.
- `rdy_in` input 1: global enable; low freezes all state.
- `clr_in` input 1: misprediction flush.
- `mem_din` input 8: RAM/IO read byte.
- `mem_dout` output 8: RAM/IO write byte.
- `mem_a` output 32: byte address.
- `mem_wr` output 1: 1 = write, 0 = read.
- `io_buffer_full` input 1: UART buffer full.
- `if_to_mc_ready` input 1: fetch request, held until served.
- `if_to_mc_PC` input 32: fetch address.
- `mc_to_if_ready` output 1: fetch done pulse.
- `mc_to_if_inst` output 32: fetched word.
- `mc_to_if_addr` output 32: address of the fetched word.
- `lsb_to_mc_ready` input 1: LSB request, held until served.
- `lsb_to_mc_wr` input 1: 1 = store.
- `lsb_to_mc_addr` input 32: base address.
- `lsb_to_mc_len` input 2: 00 = byte, 01 = half, 10/11 = word.
- `lsb_to_mc_data` input 32: store data (little-endian).
- `mc_to_lsb_ready` output 1: LSB done pulse.
- `mc_to_lsb_data` output 32: load data, zero-extended.

## Operation
- States: IDLE, READ, WRITE, DONE.
- `cnt` holds the byte index. N is the byte count: 4 for fetch; 1, 2 or 4 for the LSB.
- IDLE:
  - Samples requests at the clock edge.
  - If both requesters are active, priority follows the Configuration section.
  - Latches base address, N and requester.
  - Moves to READ, or to WRITE for a store.
  - `cnt` is set to 0.
- READ:
  - Cycle i (0..N−1) drives `mem_a` = base+i, `mem_wr` = 0.
  - The byte for address i appears on `mem_din` in cycle i+1 and is captured into byte lane i.
  - On the edge that captures byte N−1 (end of cycle N), go to DONE.
- WRITE:
  - Cycle i drives `mem_a` = base+i, `mem_wr` = 1, `mem_dout` = data[8i+7:8i].
  - IO stall: if base[17:16] = 2'b11 and `io_buffer_full` = 1, drive `mem_wr` = 0 and do not advance `cnt` that cycle.
  - After byte N−1 is written, go to DONE.
- DONE (one cycle):
  - Asserts exactly one of `mc_to_if_ready` / `mc_to_lsb_ready`, with data and address valid.
  - Requests are ignored in this cycle.
  - Next state is IDLE.
- Addresses are 32-bit with wrap-around: base+i mod 2^32.
- Load bytes above N are zero.
- `mc_to_if_addr` = latched base.
- `mem_wr` is 0 in every state other than an active WRITE byte cycle.
- `clr_in`:
  - IDLE: pending fetch and load requests are dropped that cycle; a store is accepted.
  - READ: abort to IDLE with no done pulse.
  - WRITE: the store completes normally (stores are committed).
  - DONE: the registered pulse still appears; requesters ignore it under `clr_in`.
- `rdy_in` = 0: all registers hold and `mem_wr` is forced to 0.
- Reset value of every output is 0. State is IDLE and the last-served pointer is IF.

## Timing
- Request first visible in cycle R; the transaction starts at R+1.
- Read: DONE is in cycle R+N+2. A word fetch or load completes at R+6; a byte load at R+3.
- Write: DONE at R+N+1 plus any IO stall cycles.
- The earliest next grant is sampled in the IDLE cycle after DONE.
- Back-to-back word fetches complete every 7 cycles.

## Configuration
- `MC_ROUND_ROBIN_EN` defined:
  - With simultaneous requests, serve the requester not served last.
  - The last-served pointer updates at each grant.
- Not defined: fixed priority, LSB always wins over IF.

## Test plan
- Reset, then fetch PC = 0x00000010 with RAM[0x10..0x13] = 13 05 00 00:
  - `mem_a` = 0x10..0x13 in cycles R+1..R+4.
  - `mc_to_if_inst` = 0x00000513 and `mc_to_if_ready` pulse at R+6.
- Half load at 0x1FFFE with bytes 0x34 0x82: `mc_to_lsb_data` = 0x00008234 at R+4.
- Word store 0xDEADBEEF at 0x100: `mem_wr` = 1 for 4 cycles with `mem_dout` = EF BE AD DE; `mc_to_lsb_ready` at R+5.
- Byte store to 0x30000 with `io_buffer_full` high for 3 cycles: write delayed 3 cycles; exactly one `mem_wr` cycle.
- Simultaneous IF and LSB loads, repeated twice:
  - Macro on: order is LSB, IF, LSB, IF.
  - Macro off: LSB is served first whenever both are waiting.
- `clr_in` at cycle R+2 of a fetch: returns to IDLE with no `mc_to_if_ready`. The same pulse during a word store does not shorten the store; `mc_to_lsb_ready` still arrives at R+5.
